mips_multicycle: RTL and testbench

MIPS_MULTICYCLE -- requirements
Module: mips_multicycle

---
 rtl/mips_multicycle.sv | 266 ++++++++++++++++++++++++++
 tb/tb_mips_multicycle.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle.sv
// rtl/mips_multicycle.sv - multicycle MIPS subset core with loadable instruction memory
module mips_multicycle #(
    parameter int DATA_W     = 32,
    parameter int IMEM_DEPTH = 256,
    parameter int DMEM_DEPTH = 256
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          load_en,
    input  logic [$clog2(IMEM_DEPTH)-1:0] load_addr,
    input  logic [31:0]                   load_data,
    input  logic                          start,
    output logic [DATA_W-1:0]             pc_out,
    output logic [DATA_W-1:0]             alu_result,
    output logic                          busy,
    output logic                          instr_done,
    output logic                          halted
);
    localparam int IAW = $clog2(IMEM_DEPTH);
    localparam int DAW = $clog2(DMEM_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    typedef enum logic [2:0] {
        C_NOP, C_RTYPE, C_ADDI, C_LW, C_SW, C_BEQ, C_J, C_HALT
    } cls_t;

    state_t            state_q, state_d;
    cls_t              cls;
    logic [31:0]       ir_q, ir_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] alu_q, alu_d;
    logic [DATA_W-1:0] mdr_q, mdr_d;
    logic [DATA_W-1:0] regs_q [32];
    logic [31:0]       imem [IMEM_DEPTH];
    logic [DATA_W-1:0] dmem [DMEM_DEPTH];

    logic [5:0]        opcode, funct;
    logic [4:0]        rs, rt, rd;
    logic [DATA_W-1:0] rs_val, rt_val, simm;
    logic [DATA_W-1:0] pc_plus4, br_target, j_target, alu_out;
    logic              imem_oob, dmem_ok, idle_like;
    logic [4:0]        wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              wb_en;
    logic              unused_shamt;

    assign opcode    = ir_q[31:26];
    assign rs        = ir_q[25:21];
    assign rt        = ir_q[20:16];
    assign rd        = ir_q[15:11];
    assign funct     = ir_q[5:0];
    assign unused_shamt = ^ir_q[10:6];

    // $0 is never written, so its flop stays at the reset value of zero
    assign rs_val    = regs_q[rs];
    assign rt_val    = regs_q[rt];
    assign simm      = {{(DATA_W-16){ir_q[15]}}, ir_q[15:0]};
    assign pc_plus4  = pc_q + DATA_W'(4);
    assign br_target = pc_plus4 + (simm << 2);
    assign j_target  = {pc_plus4[DATA_W-1:28], ir_q[25:0], 2'b00};
    assign imem_oob  = (pc_q >> 2) >= DATA_W'(IMEM_DEPTH);
    assign dmem_ok   = (alu_q >> 2) < DATA_W'(DMEM_DEPTH);
    assign idle_like = (state_q == S_IDLE) || (state_q == S_HALT);

    // classify the held instruction; anything unrecognised retires as a NOP
    always_comb begin
        cls = C_NOP;
        if (ir_q == 32'hFFFF_FFFF) begin
            cls = C_HALT;
        end else begin
            case (opcode)
                6'h00: begin
                    case (funct)
                        6'h20, 6'h22, 6'h24, 6'h25, 6'h2A: cls = C_RTYPE;
                        default:                           cls = C_NOP;
                    endcase
                end
                6'h08:   cls = C_ADDI;
                6'h23:   cls = C_LW;
                6'h2B:   cls = C_SW;
                6'h04:   cls = C_BEQ;
                6'h02:   cls = C_J;
                default: cls = C_NOP;
            endcase
        end
    end

    // ALU: R-type by funct, beq compares by subtraction, the rest form rs+simm
    always_comb begin
        alu_out = rs_val + simm;
        if (cls == C_RTYPE) begin
            case (funct)
                6'h22:   alu_out = rs_val - rt_val;
                6'h24:   alu_out = rs_val & rt_val;
                6'h25:   alu_out = rs_val | rt_val;
                6'h2A:   alu_out = ($signed(rs_val) < $signed(rt_val)) ? DATA_W'(1) : '0;
                default: alu_out = rs_val + rt_val;
            endcase
        end else if (cls == C_BEQ) begin
            alu_out = rs_val - rt_val;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: one state per cycle, length set by instruction class
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_HALT: begin
                if (start && !load_en) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH:  state_d = imem_oob ? S_HALT : S_DECODE;
            S_DECODE: begin
                if (cls == C_HALT) begin
                    state_d = S_HALT;
                end else if (cls == C_NOP) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                case (cls)
                    C_BEQ, C_J: state_d = S_FETCH;
                    C_LW, C_SW: state_d = S_MEM;
                    default:    state_d = S_WB;
                endcase
            end
            S_MEM:   state_d = (cls == C_LW) ? S_WB : S_FETCH;
            S_WB:    state_d = S_FETCH;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: done pulses on the cycle that hands back to FETCH
    always_comb begin
        busy       = 1'b0;
        halted     = 1'b0;
        instr_done = 1'b0;
        case (state_q)
            S_FETCH:  busy = 1'b1;
            S_DECODE: begin
                busy       = 1'b1;
                instr_done = (cls == C_NOP);
            end
            S_EXEC: begin
                busy       = 1'b1;
                instr_done = (cls == C_BEQ) || (cls == C_J);
            end
            S_MEM: begin
                busy       = 1'b1;
                instr_done = (cls == C_SW);
            end
            S_WB: begin
                busy       = 1'b1;
                instr_done = 1'b1;
            end
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
    end

    // datapath next values; PC only moves on an instruction's final cycle
    always_comb begin
        pc_d  = pc_q;
        ir_d  = ir_q;
        alu_d = alu_q;
        mdr_d = mdr_q;
        case (state_q)
            S_IDLE, S_HALT: begin
                if (start && !load_en) begin
                    pc_d = '0;
                end
            end
            S_FETCH: begin
                if (!imem_oob) begin
                    ir_d = imem[pc_q[IAW+1:2]];
                end
            end
            S_DECODE: begin
                if (cls == C_NOP) begin
                    pc_d = pc_plus4;
                end
            end
            S_EXEC: begin
                if (cls == C_J) begin
                    pc_d = j_target;
                end else begin
                    alu_d = alu_out;
                    if (cls == C_BEQ) begin
                        pc_d = (rs_val == rt_val) ? br_target : pc_plus4;
                    end
                end
            end
            S_MEM: begin
                mdr_d = dmem_ok ? dmem[alu_q[DAW+1:2]] : '0;
                if (cls == C_SW) begin
                    pc_d = pc_plus4;
                end
            end
            S_WB:    pc_d = pc_plus4;
            default: ;
        endcase
    end

    // datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q  <= '0;
            ir_q  <= '0;
            alu_q <= '0;
            mdr_q <= '0;
        end else begin
            pc_q  <= pc_d;
            ir_q  <= ir_d;
            alu_q <= alu_d;
            mdr_q <= mdr_d;
        end
    end

    assign wb_addr = (cls == C_RTYPE) ? rd : rt;
    assign wb_data = (cls == C_LW) ? mdr_q : alu_q;
    assign wb_en   = (state_q == S_WB) && (wb_addr != 5'd0);

    // register file: cleared by reset, single write port active in WB
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_en) begin
            regs_q[wb_addr] <= wb_data;
        end
    end

    // instruction memory: loadable only while the core is parked
    always_ff @(posedge clk) begin
        if (reset && load_en && idle_like) begin
            imem[load_addr] <= load_data;
        end
    end

    // data memory: sw writes in MEM, out-of-range stores are dropped
    always_ff @(posedge clk) begin
        if (reset && (state_q == S_MEM) && (cls == C_SW) && dmem_ok) begin
            dmem[alu_q[DAW+1:2]] <= rt_val;
        end
    end

    assign pc_out     = pc_q;
    assign alu_result = alu_q;

endmodule

// File: tb/tb_mips_multicycle.sv
// tb/tb_mips_multicycle.sv - directed and randomized checks of mips_multicycle against an ISA model
module tb_mips_multicycle;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  load_en = 3'b000;
    logic [2:0]  start = 3'b000;
    logic [7:0]  load_addr = 8'd0;
    logic [31:0] load_data = 32'd0;

    logic [31:0] pc_a, alu_a, pc_b, alu_b;
    logic [63:0] pc_c, alu_c;
    logic        busy_a, done_a, halted_a;
    logic        busy_b, done_b, halted_b;
    logic        busy_c, done_c, halted_c;

    int          sel = 0;
    logic [63:0] pc_s, alu_s;
    logic        busy_s, done_s, halted_s;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // reference model state
    logic [31:0] prog [256];
    logic [63:0] mregs [32];
    logic [63:0] mdmem [logic [63:0]];
    logic [63:0] malu = 64'd0;
    logic [63:0] mpc  = 64'd0;
    int          mw = 32;
    int          mdepth = 256;
    logic [63:0] exp_alu [$];
    logic [63:0] exp_pc [$];
    int          exp_cyc;

    logic [63:0] obs_alu [$];
    logic [63:0] obs_pc [$];
    int          r_pulses, r_cyc;

    always #5 clk = ~clk;

    mips_multicycle #(.DATA_W(32), .IMEM_DEPTH(256), .DMEM_DEPTH(256)) u_a (
        .clk(clk), .reset(reset), .load_en(load_en[0]), .load_addr(load_addr),
        .load_data(load_data), .start(start[0]), .pc_out(pc_a), .alu_result(alu_a),
        .busy(busy_a), .instr_done(done_a), .halted(halted_a));

    mips_multicycle #(.DATA_W(32), .IMEM_DEPTH(4), .DMEM_DEPTH(256)) u_b (
        .clk(clk), .reset(reset), .load_en(load_en[1]), .load_addr(load_addr[1:0]),
        .load_data(load_data), .start(start[1]), .pc_out(pc_b), .alu_result(alu_b),
        .busy(busy_b), .instr_done(done_b), .halted(halted_b));

    mips_multicycle #(.DATA_W(64), .IMEM_DEPTH(256), .DMEM_DEPTH(256)) u_c (
        .clk(clk), .reset(reset), .load_en(load_en[2]), .load_addr(load_addr),
        .load_data(load_data), .start(start[2]), .pc_out(pc_c), .alu_result(alu_c),
        .busy(busy_c), .instr_done(done_c), .halted(halted_c));

    always_comb begin
        case (sel)
            1: begin
                pc_s = {32'd0, pc_b}; alu_s = {32'd0, alu_b};
                busy_s = busy_b; done_s = done_b; halted_s = halted_b;
            end
            2: begin
                pc_s = pc_c; alu_s = alu_c;
                busy_s = busy_c; done_s = done_c; halted_s = halted_c;
            end
            default: begin
                pc_s = {32'd0, pc_a}; alu_s = {32'd0, alu_a};
                busy_s = busy_a; done_s = done_a; halted_s = halted_a;
            end
        endcase
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] f_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] f_r(input logic [5:0] fn, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [4:0] rt);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    task automatic model_reset_regs();
        for (int i = 0; i < 32; i++) mregs[i] = 64'd0;
        malu = 64'd0;
    endtask

    task automatic mwr(input logic [4:0] r, input logic [63:0] v);
        if (r != 5'd0) mregs[r] = v;
    endtask

    // instruction-level interpreter: result and PC after each retired instruction
    task automatic model_run();
        logic [63:0] mask, a, b, simm, npc, res, idx;
        logic [31:0] ir;
        int cyc;
        mask = (mw == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        mpc = 64'd0;
        exp_cyc = 0;
        exp_alu.delete();
        exp_pc.delete();
        for (int step = 0; step < 400; step++) begin
            if ((mpc >> 2) >= 64'(mdepth)) begin
                exp_cyc += 1;
                return;
            end
            ir = prog[int'(mpc >> 2)];
            if (ir == 32'hFFFF_FFFF) begin
                exp_cyc += 2;
                return;
            end
            a    = mregs[ir[25:21]];
            b    = mregs[ir[20:16]];
            simm = {{48{ir[15]}}, ir[15:0]} & mask;
            npc  = (mpc + 64'd4) & mask;
            res  = 64'd0;
            cyc  = 2;
            case (ir[31:26])
                6'h00: begin
                    cyc = 4;
                    case (ir[5:0])
                        6'h20: res = a + b;
                        6'h22: res = a - b;
                        6'h24: res = a & b;
                        6'h25: res = a | b;
                        6'h2A: res = (mw == 64) ? 64'($signed(a) < $signed(b))
                                                : 64'($signed(a[31:0]) < $signed(b[31:0]));
                        default: cyc = 2;
                    endcase
                    if (cyc == 4) begin
                        malu = res & mask;
                        mwr(ir[15:11], malu);
                    end
                end
                6'h08: begin
                    malu = (a + simm) & mask;
                    mwr(ir[20:16], malu);
                    cyc = 4;
                end
                6'h23: begin
                    malu = (a + simm) & mask;
                    idx  = malu >> 2;
                    mwr(ir[20:16], (idx < 64'd256 && mdmem.exists(idx)) ? mdmem[idx] : 64'd0);
                    cyc = 5;
                end
                6'h2B: begin
                    malu = (a + simm) & mask;
                    idx  = malu >> 2;
                    if (idx < 64'd256) mdmem[idx] = b;
                    cyc = 4;
                end
                6'h04: begin
                    malu = (a - b) & mask;
                    if (a == b) npc = (npc + (simm << 2)) & mask;
                    cyc = 3;
                end
                6'h02: begin
                    npc = ((npc & ~64'h0FFF_FFFF) | (64'(ir[25:0]) << 2)) & mask;
                    cyc = 3;
                end
                default: ;
            endcase
            exp_cyc += cyc;
            mpc = npc;
            exp_alu.push_back(malu);
            exp_pc.push_back(mpc);
        end
    endtask

    task automatic load_word(input int a, input logic [31:0] d);
        @(negedge clk);
        load_addr    = 8'(a);
        load_data    = d;
        load_en[sel] = 1'b1;
        @(posedge clk);
        #1 load_en[sel] = 1'b0;
    endtask

    task automatic load_n(input int n);
        for (int i = 0; i < n; i++) load_word(i, prog[i]);
    endtask

    // run from PC 0 until halted; pokes start/load once mid-run, which must be ignored
    task automatic run_prog(input string tag, input int tamper_addr);
        int pend;
        model_run();
        @(negedge clk);
        start[sel] = 1'b1;
        @(posedge clk);
        #1 start[sel] = 1'b0;
        obs_alu.delete();
        obs_pc.delete();
        r_pulses = 0;
        r_cyc = 0;
        pend = 0;
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            if (pend != 0) begin
                obs_alu.push_back(alu_s);
                obs_pc.push_back(pc_s);
                pend = 0;
            end
            if (halted_s) break;
            if (busy_s) r_cyc++;
            if (done_s) begin
                r_pulses++;
                pend = 1;
            end
            if (r_cyc == 2) begin
                start[sel]   = 1'b1;
                load_en[sel] = 1'b1;
                load_addr    = 8'(tamper_addr);
                load_data    = 32'h2001_0001;
            end else begin
                start[sel]   = 1'b0;
                load_en[sel] = 1'b0;
            end
        end
        start[sel]   = 1'b0;
        load_en[sel] = 1'b0;
        chk({tag, "_halted"}, 64'(halted_s), 64'd1);
        chk({tag, "_busy_off"}, 64'(busy_s), 64'd0);
        chk({tag, "_pulses"}, 64'(r_pulses), 64'(exp_alu.size()));
        chk({tag, "_cycles"}, 64'(r_cyc), 64'(exp_cyc));
        chk({tag, "_final_pc"}, pc_s, mpc);
        for (int i = 0; i < exp_alu.size() && i < obs_alu.size(); i++) begin
            chk($sformatf("%s_alu%0d", tag, i), obs_alu[i], exp_alu[i]);
            chk($sformatf("%s_pc%0d", tag, i), obs_pc[i], exp_pc[i]);
        end
    endtask

    function automatic logic [15:0] mem_off();
        case ($urandom_range(0, 5))
            0:       return 16'h4000;
            1:       return 16'hFFFC;
            default: return 16'($urandom_range(0, 7) * 4);
        endcase
    endfunction

    task automatic gen_random(input int n);
        logic [4:0] r1, r2, r3;
        logic [5:0] fn;
        int span, tgt;
        for (int i = 0; i < n; i++) begin
            r1 = 5'($urandom_range(0, 7));
            r2 = 5'($urandom_range(0, 7));
            r3 = 5'($urandom_range(0, 3));
            case ($urandom_range(0, 4))
                0:       fn = 6'h20;
                1:       fn = 6'h22;
                2:       fn = 6'h24;
                3:       fn = 6'h25;
                default: fn = 6'h2A;
            endcase
            span = n - i - 1;
            case ($urandom_range(0, 9))
                0, 1: prog[i] = f_i(6'h08, r2, r1, 16'($urandom));
                2, 3: prog[i] = f_r(fn, r1, r2, r3);
                4:    prog[i] = f_i(6'h2B, 5'd0, r1, mem_off());
                5:    prog[i] = f_i(6'h23, 5'd0, r1, mem_off());
                6:    prog[i] = f_i(6'h04, r3, 5'($urandom_range(0, 3)),
                                    16'($urandom_range(0, (span > 2) ? 2 : span)));
                7: begin
                    tgt = $urandom_range(i + 1, n);
                    prog[i] = {6'h02, 26'(tgt)};
                end
                8:       prog[i] = {6'h3E, 26'($urandom)};
                default: prog[i] = f_r(6'h01, r1, r2, r3);
            endcase
        end
        prog[n] = 32'hFFFF_FFFF;
    endtask

    initial begin
        model_reset_regs();

        // reset state
        #12;
        chk("rst_pc", pc_s, 64'd0);
        chk("rst_alu", alu_s, 64'd0);
        chk("rst_busy", 64'(busy_s), 64'd0);
        chk("rst_done", 64'(done_s), 64'd0);
        chk("rst_halted", 64'(halted_s), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_after_release", 64'(busy_s), 64'd0);

        // load with start raised together: load wins, core stays idle
        @(negedge clk);
        load_addr = 8'd0; load_data = 32'hFFFF_FFFF; load_en[0] = 1'b1; start[0] = 1'b1;
        @(posedge clk);
        #1 load_en[0] = 1'b0; start[0] = 1'b0;
        @(negedge clk);
        chk("load_beats_start", 64'(busy_s), 64'd0);

        // sample program: add/sw/lw/add then halt
        prog[0] = f_i(6'h08, 5'd0, 5'd1, 16'd5);
        prog[1] = f_i(6'h08, 5'd0, 5'd2, 16'd7);
        prog[2] = f_r(6'h20, 5'd3, 5'd1, 5'd2);
        prog[3] = f_i(6'h2B, 5'd0, 5'd3, 16'd0);
        prog[4] = f_i(6'h23, 5'd0, 5'd4, 16'd0);
        prog[5] = f_r(6'h20, 5'd5, 5'd4, 5'd0);
        prog[6] = 32'hFFFF_FFFF;
        load_n(7);
        run_prog("basic", 6);
        chk("basic_add", obs_alu[2], 64'd12);
        chk("basic_sw", obs_alu[3], 64'd0);
        chk("basic_lw", obs_alu[4], 64'd0);
        chk("basic_add2", obs_alu[5], 64'd12);
        chk("basic_npulse", 64'(r_pulses), 64'd6);
        chk("basic_ncyc", 64'(r_cyc), 64'd27);
        chk("basic_pc", pc_s, 64'd24);

        // writes to $0 are discarded
        prog[0] = f_i(6'h08, 5'd0, 5'd0, 16'd9);
        prog[1] = f_r(6'h20, 5'd6, 5'd0, 5'd0);
        prog[2] = 32'hFFFF_FFFF;
        load_n(3);
        run_prog("zero", 2);
        chk("zero_addi", obs_alu[0], 64'd9);
        chk("zero_add", obs_alu[1], 64'd0);

        // beq taken and not taken
        prog[0] = f_i(6'h04, 5'd0, 5'd0, 16'd2);
        prog[1] = f_i(6'h08, 5'd0, 5'd1, 16'd1);
        prog[2] = f_i(6'h08, 5'd0, 5'd1, 16'd2);
        prog[3] = 32'hFFFF_FFFF;
        load_n(4);
        run_prog("beq_t", 3);
        chk("beq_taken_pc", obs_pc[0], 64'd12);
        prog[0] = f_i(6'h04, 5'd1, 5'd0, 16'd2);
        prog[1] = 32'hFFFF_FFFF;
        load_n(2);
        run_prog("beq_nt", 1);
        chk("beq_not_taken_pc", obs_pc[0], 64'd4);

        // seed dmem words 0..7 from registers so random loads read defined data
        for (int k = 0; k < 8; k++) prog[k] = f_i(6'h2B, 5'd0, 5'(k), 16'(k * 4));
        prog[8] = 32'hFFFF_FFFF;
        load_n(9);
        run_prog("dmem_init", 8);

        // random programs, state carried over between runs
        for (int p = 0; p < 6; p++) begin
            gen_random(12);
            load_n(13);
            run_prog($sformatf("rnd%0d", p), 12);
        end

        // reset during WB aborts the register write
        prog[0] = f_i(6'h08, 5'd0, 5'd7, 16'd3);
        prog[1] = 32'hFFFF_FFFF;
        load_n(2);
        @(negedge clk);
        start[0] = 1'b1;
        @(posedge clk);
        #1 start[0] = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("wb_busy", 64'(busy_s), 64'd1);
        chk("wb_done", 64'(done_s), 64'd1);
        reset = 1'b0;
        #1;
        chk("mid_rst_busy", 64'(busy_s), 64'd0);
        chk("mid_rst_done", 64'(done_s), 64'd0);
        chk("mid_rst_halted", 64'(halted_s), 64'd0);
        chk("mid_rst_pc", pc_s, 64'd0);
        chk("mid_rst_alu", alu_s, 64'd0);
        model_reset_regs();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_idle", 64'(busy_s), 64'd0);
        prog[0] = f_r(6'h20, 5'd8, 5'd7, 5'd0);
        load_word(0, prog[0]);
        run_prog("after_rst", 1);
        chk("after_rst_alu", obs_alu[0], 64'd0);

        // four-word instruction memory runs off the end
        sel = 1;
        mw = 32; mdepth = 4;
        model_reset_regs();
        mdmem.delete();
        prog[0] = f_i(6'h08, 5'd0, 5'd1, 16'd1);
        prog[1] = f_i(6'h08, 5'd1, 5'd2, 16'd2);
        prog[2] = f_i(6'h08, 5'd2, 5'd3, 16'd3);
        prog[3] = f_i(6'h08, 5'd3, 5'd4, 16'd4);
        load_n(4);
        run_prog("oob", 3);
        chk("oob_pc", pc_s, 64'd16);
        chk("oob_npulse", 64'(r_pulses), 64'd4);

        // 64-bit datapath: sign extension and signed slt
        sel = 2;
        mw = 64; mdepth = 256;
        model_reset_regs();
        prog[0] = f_i(6'h08, 5'd0, 5'd1, 16'hFFFF);
        prog[1] = f_r(6'h2A, 5'd2, 5'd1, 5'd0);
        prog[2] = 32'hFFFF_FFFF;
        load_n(3);
        run_prog("w64", 2);
        chk("w64_addi", obs_alu[0], 64'hFFFF_FFFF_FFFF_FFFF);
        chk("w64_slt", obs_alu[1], 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
